// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control decoder: 1-cycle latency, MUL_LAT/DIV_LAT cycles for mult/div.
// Output holds while out_ready is low; in_ready drops in BUSY and in HOLD without out_ready.
module alu_ctrl_pipe #(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_op,
  input  logic [5:0]        funct,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_control,
  output logic              illegal,
  output logic              multi,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;

  logic [3:0]       dec_code;
  logic             dec_illegal;
  logic             dec_multi;
  logic             dec_div;
  logic             accept;
  logic             one_cycle;
  logic [CNT_W-1:0] load_cnt;

  always_comb begin
    dec_code    = 4'b0010;
    dec_illegal = 1'b0;
    dec_multi   = 1'b0;
    dec_div     = 1'b0;
    case (alu_op)
      3'b000: dec_code = 4'b0010;
      3'b001: dec_code = 4'b0110;
      3'b011: dec_code = 4'b0000;
      3'b100: dec_code = 4'b0001;
      3'b101: dec_code = 4'b0111;
      3'b110: dec_code = 4'b0011;
      3'b111: dec_code = 4'b1111;
      default: begin
        case (funct)
          6'b100000, 6'b100001: dec_code = 4'b0010;
          6'b100010, 6'b100011: dec_code = 4'b0110;
          6'b100100: dec_code = 4'b0000;
          6'b100101: dec_code = 4'b0001;
          6'b100110: dec_code = 4'b0011;
          6'b100111: dec_code = 4'b0100;
          6'b101010: dec_code = 4'b0111;
          6'b101011: dec_code = 4'b1111;
          6'b000000: dec_code = 4'b1000;
          6'b000010: dec_code = 4'b1001;
          6'b000011: dec_code = 4'b1010;
          6'b011000: begin
            dec_code  = 4'b1100;
            dec_multi = 1'b1;
          end
          6'b011010: begin
            dec_code  = 4'b1101;
            dec_multi = 1'b1;
            dec_div   = 1'b1;
          end
          default: begin
            dec_code    = 4'b0010;
            dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  // Count loads LAT-1 so out_valid rises exactly LAT edges after the accept edge.
  assign load_cnt  = dec_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
  assign one_cycle = dec_div ? (DIV_LAT == 1) : (MUL_LAT == 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      out_valid   <= 1'b0;
      alu_control <= '0;
      illegal     <= 1'b0;
      multi       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            alu_control <= CTRL_W'(dec_code);
            illegal     <= dec_illegal;
            multi       <= dec_multi;
            if (dec_multi && !one_cycle) begin
              state     <= BUSY;
              count     <= load_cnt;
              busy      <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end else if (state == HOLD && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        BUSY: begin
          if (count == '0) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed bench for alu_ctrl_pipe at default parameters (MUL_LAT=4, DIV_LAT=32).
module tb_alu_ctrl_pipe;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] alu_op;
  logic [5:0] funct;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_control;
  logic       illegal;
  logic       multi;
  logic       busy;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  alu_ctrl_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .funct       (funct),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_control (alu_control),
    .illegal     (illegal),
    .multi       (multi),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [5:0] fn);
    in_valid = 1'b1;
    alu_op   = op;
    funct    = fn;
  endtask

  logic [2:0] s_op  [8] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};
  logic [3:0] s_exp [8] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h7, 4'h3, 4'hF, 4'hA};
  logic [5:0] r_fn  [11] = '{6'b100001, 6'b100111, 6'b000000, 6'b000010, 6'b101011, 6'b100100,
                             6'b100101, 6'b100110, 6'b101010, 6'b100000, 6'b100011};
  logic [3:0] r_exp [11] = '{4'h2, 4'h4, 4'h8, 4'h9, 4'hF, 4'h0, 4'h1, 4'h3, 4'h7, 4'h2, 4'h6};

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    alu_op    = 3'b000;
    funct     = 6'b000000;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_ctrl", 32'(alu_control), 0);
    chk("rst_flags", 32'({illegal, multi}), 0);

    // R-type SUB, latency 1
    send(3'b010, 6'b100010);
    step();
    chk("sub_valid", 32'(out_valid), 1);
    chk("sub_ctrl", 32'(alu_control), 'h6);
    chk("sub_illegal", 32'(illegal), 0);

    // Unsupported funct reloaded straight from HOLD
    send(3'b010, 6'b111111);
    step();
    chk("ill_valid", 32'(out_valid), 1);
    chk("ill_ctrl", 32'(alu_control), 'h2);
    chk("ill_flags", 32'({illegal, multi}), 'b10);
    in_valid = 1'b0;
    step();
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_hold_ctrl", 32'(alu_control), 'h2);
    chk("idle_in_ready", 32'(in_ready), 1);

    // DIV: 32 busy cycles, then output
    send(3'b010, 6'b011010);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (busy && !out_valid && !in_ready) n++;
      step();
    end
    chk("div_busy_cycles", 32'(n), 32);
    chk("div_valid", 32'(out_valid), 1);
    chk("div_ctrl", 32'(alu_control), 'hD);
    chk("div_multi", 32'(multi), 1);
    chk("div_busy_done", 32'(busy), 0);

    // HOLD stalled 5 cycles with a request pending
    send(3'b000, 6'b011010);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid && alu_control == 4'hD && multi && !in_ready) n++;
      step();
    end
    chk("hold_stable", 32'(n), 5);
    out_ready = 1'b1;
    #1;
    chk("hold_release_ready", 32'(in_ready), 1);
    step();
    chk("hold_new_valid", 32'(out_valid), 1);
    chk("hold_new_ctrl", 32'(alu_control), 'h2);
    chk("funct_ignored_multi", 32'(multi), 0);

    // Back-to-back stream
    n = 0;
    for (int i = 0; i < 8; i++) begin
      send(s_op[i], 6'b000011);
      step();
      if (out_valid && alu_control == s_exp[i]) n++;
    end
    chk("stream_count", 32'(n), 8);
    chk("stream_last_ctrl", 32'(alu_control), 'hA);
    chk("stream_last_illegal", 32'(illegal), 0);

    // Remaining R-type functs
    for (int i = 0; i < 11; i++) begin
      send(3'b010, r_fn[i]);
      step();
      chk("rtype_ctrl", 32'({out_valid, illegal, alu_control}), 32'({2'b10, r_exp[i]}));
    end
    in_valid = 1'b0;
    step();
    chk("rtype_drain", 32'(out_valid), 0);

    // MULT latency 4
    send(3'b010, 6'b011000);
    step();
    in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) break;
      n++;
      step();
    end
    chk("mult_latency", 32'(n), 4);
    chk("mult_ctrl", 32'({multi, alu_control}), 'h1C);
    step();

    // Reset in BUSY at count=10 discards the op
    send(3'b010, 6'b011010);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 21; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy_cleared", 32'({busy, out_valid}), 0);
    chk("rst_busy_in_ready", 32'(in_ready), 1);
    chk("rst_busy_ctrl", 32'(alu_control), 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid || busy) n++;
    end
    chk("rst_no_output", 32'(n), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
